// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master
// Description : Clause 22 / Clause 45 MDIO management master with MDC divider.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_master #(
    parameter int CLK_DIV      = 2,
    parameter int PREAMBLE_LEN = 32,
    parameter bit C45_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        c45,
    input  logic [1:0]  op,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        ta_err,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);

    localparam int                c_cnt_w    = $clog2(2 * CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_half    = c_cnt_w'(CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(2 * CLK_DIV - 1);
    localparam logic [4:0]        c_pre_last = (PREAMBLE_LEN > 0) ? 5'(PREAMBLE_LEN - 1) : 5'd0;

    typedef enum logic [3:0] {
        c_idle = 4'd0, c_pre = 4'd1, c_st = 4'd2, c_op = 4'd3, c_pa = 4'd4,
        c_ra = 4'd5, c_ta = 4'd6, c_data = 4'd7, c_done = 4'd8
    } state_t;

    state_t               r_state_q, w_state_d, w_nxt_state;
    logic [4:0]           r_left_q, w_left_d, w_nxt_left;
    logic [c_cnt_w-1:0]   r_cnt_q, w_cnt_d, w_cnt_inc;
    logic [31:0]          r_sh_q, w_sh_d;
    logic [15:0]          r_rd_sh_q, w_rd_sh_d, r_rd_data_q, w_rd_data_d;
    logic                 r_is_read_q, w_is_read_d, r_ta_bad_q, w_ta_bad_d;
    logic                 r_busy_q, w_busy_d, r_done_q, w_done_d, r_ta_err_q, w_ta_err_d;
    logic                 r_mdc_q, w_mdc_d, r_out_q, w_out_d, r_oe_q, w_oe_d;
    logic                 w_bit_end, w_c45_eff, w_req_read;
    logic [1:0]           w_req_st;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= c_idle;
            r_left_q    <= '0;
            r_cnt_q     <= '0;
            r_sh_q      <= '0;
            r_rd_sh_q   <= '0;
            r_rd_data_q <= '0;
            r_is_read_q <= 1'b0;
            r_ta_bad_q  <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_ta_err_q  <= 1'b0;
            r_mdc_q     <= 1'b0;
            r_out_q     <= 1'b1;
            r_oe_q      <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_left_q    <= w_left_d;
            r_cnt_q     <= w_cnt_d;
            r_sh_q      <= w_sh_d;
            r_rd_sh_q   <= w_rd_sh_d;
            r_rd_data_q <= w_rd_data_d;
            r_is_read_q <= w_is_read_d;
            r_ta_bad_q  <= w_ta_bad_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_ta_err_q  <= w_ta_err_d;
            r_mdc_q     <= w_mdc_d;
            r_out_q     <= w_out_d;
            r_oe_q      <= w_oe_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_left_d    = r_left_q;
        w_cnt_d     = r_cnt_q;
        w_sh_d      = r_sh_q;
        w_rd_sh_d   = r_rd_sh_q;
        w_rd_data_d = r_rd_data_q;
        w_is_read_d = r_is_read_q;
        w_ta_bad_d  = r_ta_bad_q;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;
        w_ta_err_d  = r_ta_err_q;
        w_mdc_d     = r_mdc_q;
        w_out_d     = r_out_q;
        w_oe_d      = r_oe_q;
        w_cnt_inc   = r_cnt_q + 1'b1;
        w_bit_end   = (r_cnt_q == c_last);
        w_c45_eff   = c45 & C45_EN;
        w_req_read  = w_c45_eff ? op[1] : (op == 2'b10);
        w_req_st    = w_c45_eff ? 2'b00 : 2'b01;

        // field sequencing: w_nxt_* is where the frame goes after the current bit
        case (r_state_q)
            c_pre:   begin w_nxt_state = c_st;   w_nxt_left = 5'd1;  end
            c_st:    begin w_nxt_state = c_op;   w_nxt_left = 5'd1;  end
            c_op:    begin w_nxt_state = c_pa;   w_nxt_left = 5'd4;  end
            c_pa:    begin w_nxt_state = c_ra;   w_nxt_left = 5'd4;  end
            c_ra:    begin w_nxt_state = c_ta;   w_nxt_left = 5'd1;  end
            c_ta:    begin w_nxt_state = c_data; w_nxt_left = 5'd15; end
            default: begin w_nxt_state = c_done; w_nxt_left = 5'd0;  end
        endcase
        if (r_left_q != 5'd0) begin
            w_nxt_state = r_state_q;
            w_nxt_left  = r_left_q - 5'd1;
        end

        if (r_state_q == c_idle || r_state_q == c_done) begin
            w_state_d = c_idle;
            w_busy_d  = 1'b0;
            w_mdc_d   = 1'b0;
            w_oe_d    = 1'b0;
            w_out_d   = 1'b1;
            if (start) begin
                w_state_d   = (PREAMBLE_LEN > 0) ? c_pre : c_st;
                w_left_d    = (PREAMBLE_LEN > 0) ? c_pre_last : 5'd1;
                w_cnt_d     = '0;
                w_sh_d      = {w_req_st, op, phy_addr, reg_addr,
                               w_req_read ? 2'b11 : 2'b10,
                               w_req_read ? 16'hFFFF : wr_data};
                w_is_read_d = w_req_read;
                w_ta_bad_d  = 1'b0;
                w_ta_err_d  = 1'b0;
                w_busy_d    = 1'b1;
                w_oe_d      = 1'b1;
                w_out_d     = (PREAMBLE_LEN > 0) ? 1'b1 : w_req_st[1];
            end
        end else begin
            w_cnt_d = w_cnt_inc;
            w_mdc_d = (w_cnt_inc >= c_half) && !w_bit_end;
            // first high-phase cycle is the sampling point for the responder
            if (r_cnt_q == c_half) begin
                if (r_state_q == c_ta && r_left_q == 5'd0) w_ta_bad_d = mdio_in;
                if (r_state_q == c_data) w_rd_sh_d = {r_rd_sh_q[14:0], mdio_in};
            end
            if (w_bit_end) begin
                w_cnt_d   = '0;
                w_state_d = w_nxt_state;
                w_left_d  = w_nxt_left;
                if (r_state_q != c_pre) w_sh_d = {r_sh_q[30:0], 1'b1};
                if (w_nxt_state == c_done) begin
                    w_busy_d = 1'b0;
                    w_done_d = 1'b1;
                    w_oe_d   = 1'b0;
                    w_out_d  = 1'b1;
                    if (r_is_read_q) begin
                        w_rd_data_d = w_rd_sh_d;
                        w_ta_err_d  = w_ta_bad_d;
                    end
                end else begin
                    w_out_d = (w_nxt_state == c_pre) ? 1'b1 : w_sh_d[31];
                    w_oe_d  = !(r_is_read_q && (w_nxt_state == c_ta || w_nxt_state == c_data));
                end
            end
        end
    end

    assign rd_data  = r_rd_data_q;
    assign busy     = r_busy_q;
    assign done     = r_done_q;
    assign ta_err   = r_ta_err_q;
    assign mdc      = r_mdc_q;
    assign mdio_out = r_out_q;
    assign mdio_oe  = r_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mdio_master
// Description : Self-checking bench for mdio_master with a peripheral model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_master;

    localparam int D  = 2;
    localparam int P  = 32;
    localparam int NB = P + 32;
    localparam int FL = 2 * D * NB;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start_b = 1'b0, c45 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [4:0]  phy_addr = 5'd0, reg_addr = 5'd0;
    logic [15:0] wr_data = 16'h0;
    logic        mdio_in = 1'b1, mdio_in_b = 1'b1;
    logic [15:0] rd_data, rd_data_b;
    logic        busy, done, ta_err, mdc, mdio_out, mdio_oe;
    logic        busy_b, done_b, ta_err_b, mdc_b, mdio_out_b, mdio_oe_b;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(P), .C45_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .c45(c45), .op(op),
        .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .done(done), .ta_err(ta_err), .mdc(mdc),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe), .mdio_in(mdio_in)
    );

    mdio_master #(.CLK_DIV(1), .PREAMBLE_LEN(0), .C45_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .c45(c45), .op(op),
        .phy_addr(phy_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .ta_err(ta_err_b), .mdc(mdc_b),
        .mdio_out(mdio_out_b), .mdio_oe(mdio_oe_b), .mdio_in(mdio_in_b)
    );

    typedef struct {
        logic        c45;
        logic [1:0]  op;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic        resp;
        logic        resp_ta;
        logic [15:0] resp_data;
        logic        chain;
        logic [15:0] exp_rd;
        logic        exp_ta;
    } vec_t;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] oe;
        logic [15:0] rd;
        logic        ta;
    } exp_t;

    vec_t tab[6];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] frame_of(input logic c45e, input logic [1:0] o,
                                             input logic [4:0] pa, input logic [4:0] ra,
                                             input logic [15:0] wd);
        return {(c45e ? 2'b00 : 2'b01), o, pa, ra, 2'b10, wd};
    endfunction

    function automatic logic is_rd(input logic c45e, input logic [1:0] o);
        return c45e ? o[1] : (o == 2'b10);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        c45 = v.c45; op = v.op; phy_addr = v.pa; reg_addr = v.ra; wr_data = v.wd;
        start = 1'b1;
        e.bits = {{P{1'b1}}, frame_of(v.c45, v.op, v.pa, v.ra, v.wd)};
        e.oe   = is_rd(v.c45, v.op) ? {{(P + 14){1'b1}}, 18'b0} : {64{1'b1}};
        e.rd   = v.exp_rd;
        e.ta   = v.exp_ta;
        sb.push_back(e);
    endtask

    // Runs one frame whose start was driven at the current negedge.
    task automatic run_frame(input int idx, input vec_t v, input vec_t nxt, input bit has_nxt);
        exp_t        e;
        logic [63:0] got_bits, got_oe;
        int          b, p, mdc_bad, busy_bad, early;
        got_bits = '0; got_oe = '0; mdc_bad = 0; busy_bad = 0; early = 0;
        for (int n = 1; n <= FL; n++) begin
            @(negedge clk);
            b = (n - 1) / (2 * D);
            p = (n - 1) % (2 * D);
            if (n == 1) begin
                start = 1'b0;
                check($sformatf("f%0d_busy_on_accept", idx), busy, 1);
                check($sformatf("f%0d_ta_err_cleared", idx), ta_err, 0);
            end
            if (mdc !== (p >= D)) mdc_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) early++;
            if (p == 0) begin
                got_bits[63 - b] = mdio_out;
                got_oe[63 - b]   = mdio_oe;
                // responder only drives once the master has released the line
                if (v.resp && !mdio_oe && b == P + 15)      mdio_in = v.resp_ta;
                else if (v.resp && !mdio_oe && b >= P + 16) mdio_in = v.resp_data[15 - (b - P - 16)];
                else                                        mdio_in = 1'b1;
            end
        end
        @(negedge clk);
        mdio_in = 1'b1;
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL f%0d_scoreboard: got empty queue expected entry", idx);
            return;
        end
        e = sb.pop_front();
        check($sformatf("f%0d_bits", idx), got_bits & e.oe, e.bits & e.oe);
        check($sformatf("f%0d_oe", idx), got_oe, e.oe);
        check($sformatf("f%0d_mdc_shape", idx), mdc_bad, 0);
        check($sformatf("f%0d_busy_held", idx), busy_bad, 0);
        check($sformatf("f%0d_early_done", idx), early, 0);
        check($sformatf("f%0d_done_latency", idx), done, 1);
        check($sformatf("f%0d_done_lines", idx), {busy, mdc, mdio_oe, mdio_out}, 4'b0001);
        check($sformatf("f%0d_rd_data", idx), rd_data, e.rd);
        check($sformatf("f%0d_ta_err", idx), ta_err, e.ta);
        if (has_nxt) begin
            apply(nxt);
        end else begin
            @(negedge clk);
            check($sformatf("f%0d_done_single", idx), done, 0);
            check($sformatf("f%0d_ta_err_hold", idx), ta_err, e.ta);
        end
    endtask

    initial begin
        logic [63:0] x64;
        logic [39:0] got40;
        logic [31:0] gb;
        int          b, p, early, cnt, i;

        //             c45   op     pa     ra     wd        resp  ta    rdata     chain exp_rd    exp_ta
        tab[0] = '{1'b0, 2'b01, 5'd5,  5'd3,  16'hA5A5, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tab[1] = '{1'b0, 2'b10, 5'd1,  5'd2,  16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0};
        tab[2] = '{1'b0, 2'b11, 5'd31, 5'd0,  16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0};
        tab[3] = '{1'b1, 2'b11, 5'd7,  5'd1,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        tab[4] = '{1'b1, 2'b00, 5'd7,  5'd1,  16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
        tab[5] = '{1'b0, 2'b10, 5'd9,  5'd17, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_a", {rd_data, busy, done, ta_err, mdc, mdio_out, mdio_oe}, {16'h0, 6'b000010});
        check("reset_b", {rd_data_b, busy_b, done_b, ta_err_b, mdc_b, mdio_out_b, mdio_oe_b},
              {16'h0, 6'b000010});
        @(negedge clk);

        i = 0;
        while (i < 6) begin
            apply(tab[i]);
            if (tab[i].chain && i < 5) begin
                run_frame(i, tab[i], tab[i + 1], 1'b1);
                run_frame(i + 1, tab[i + 1], tab[i + 1], 1'b0);
                i += 2;
            end else begin
                run_frame(i, tab[i], tab[i], 1'b0);
                i += 1;
            end
        end

        // second start mid-frame must be ignored; reset at bit 40 aborts without done
        c45 = 1'b0; op = 2'b01; phy_addr = 5'd5; reg_addr = 5'd3; wr_data = 16'hA5A5;
        start = 1'b1;
        got40 = '0; early = 0;
        for (int n = 1; n <= 40 * 2 * D + 1; n++) begin
            @(negedge clk);
            b = (n - 1) / (2 * D);
            p = (n - 1) % (2 * D);
            if (n == 1) start = 1'b0;
            if (done) early++;
            if (p == 0 && b < 40) got40[39 - b] = mdio_out;
            if (n == 20) begin
                op = 2'b10; phy_addr = 5'd31; reg_addr = 5'd31; wr_data = 16'h0; start = 1'b1;
            end
            if (n == 21) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        x64 = {{P{1'b1}}, frame_of(1'b0, 2'b01, 5'd5, 5'd3, 16'hA5A5)};
        check("abort_first40_bits", got40, x64[63:24]);
        check("abort_no_early_done", early, 0);
        check("abort_reset_values", {rd_data, busy, done, ta_err, mdc, mdio_out, mdio_oe},
              {16'h0, 6'b000010});
        cnt = 0;
        for (int n = 0; n < FL + 20; n++) begin
            @(negedge clk);
            if (done || busy || mdio_oe) cnt++;
        end
        check("abort_stays_idle", cnt, 0);

        // no-preamble, divide-by-1, Clause 45 disabled: c45=1 must still give ST=01
        c45 = 1'b1; op = 2'b01; phy_addr = 5'd5; reg_addr = 5'd3; wr_data = 16'hA5A5;
        start_b = 1'b1;
        gb = '0; early = 0; cnt = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (n == 1) start_b = 1'b0;
            if (done_b) early++;
            if (mdc_b !== ((n - 1) % 2 == 1)) cnt++;
            if ((n - 1) % 2 == 0) gb[31 - (n - 1) / 2] = mdio_out_b;
        end
        @(negedge clk);
        check("b_done_at_65", done_b, 1);
        check("b_early_done", early, 0);
        check("b_mdc_shape", cnt, 0);
        check("b_st_c22", gb[31:30], 2'b01);
        check("b_frame", gb, frame_of(1'b0, 2'b01, 5'd5, 5'd3, 16'hA5A5));
        check("b_scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised MDIO management master (IEEE 802.3 Clause 22 and Clause 45) that generates MDC from the system clock.
- Serialises a full management frame onto a tri-state MDIO split into out/oe/in, and captures read data plus turnaround status.
- Sits at the controller side of the MDIO subsystem and drives the peripheral block over the shared MDC/MDIO pair.
- Successor to the fixed controller: adds divider, preamble length and clause mode as parameters/inputs.

Parameters:
- CLK_DIV, 2: clk cycles per MDC half-period; legal range ≥1. One MDIO bit lasts 2*CLK_DIV clk cycles.
- PREAMBLE_LEN, 32: number of '1' preamble bits; legal range 0..32.
- C45_EN, 1: 1 = the c45 input is honoured; 0 = c45 is ignored and all frames are Clause 22.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; accepted only while busy=0
- c45  input  1  frame type: 1 = Clause 45, 0 = Clause 22
- op  input  2  frame OP field
- phy_addr  input  5  PHYAD (Clause 22) / PRTAD (Clause 45)
- reg_addr  input  5  REGAD (Clause 22) / DEVAD (Clause 45)
- wr_data  input  16  write data, or address for a Clause 45 address frame
- rd_data  output  16  captured read data
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at end of frame
- ta_err  output  1  read turnaround error; valid while done=1
- mdc  output  1  management clock
- mdio_out  output  1  MDIO drive value
- mdio_oe  output  1  1 = master drives MDIO
- mdio_in  input  1  MDIO pad input

Behaviour:
- Reset values: rd_data=0, busy=0, done=0, ta_err=0, mdc=0, mdio_out=1, mdio_oe=0. Reset mid-frame aborts immediately to these values with no done pulse.
- Request capture: when start=1 and busy=0, all request inputs are latched and busy=1 from the next cycle. start while busy is ignored; the latched fields do not change.
- States: IDLE -> PRE -> ST -> OP -> PA -> RA -> TA -> DATA -> DONE -> IDLE. PRE is skipped when PREAMBLE_LEN=0.
- Bit timing: each bit has a low phase of CLK_DIV cycles (mdc=0) followed by a high phase of CLK_DIV cycles (mdc=1).
  - mdio_out/mdio_oe update on the first cycle of the low phase.
  - mdio_in is sampled on the cycle mdc transitions 0->1.
  - mdc stays 0 in IDLE.
- Bit count: frame length is PREAMBLE_LEN+32 bits. Fields are sent MSB first.
  - ST = 01 for Clause 22, 00 for Clause 45.
  - Then OP[1:0], PA[4:0], RA[4:0], TA (2 bits), DATA[15:0].
- Read decision: is_read = (!c45_eff && op==2'b10) || (c45_eff && op[1]), where c45_eff = c45 & C45_EN.
- Write or address frame: mdio_oe=1 for the whole frame; TA driven as 1,0; DATA = wr_data.
- Read frame:
  - mdio_oe=1 through RA, then mdio_oe=0 from the first TA bit to end of frame.
  - Second TA bit sampled as 1 sets ta_err=1.
  - DATA bits are shifted into an internal register; rd_data updates only in DONE.
- DONE: one cycle with done=1, busy=0, mdc=0, mdio_oe=0, mdio_out=1; then IDLE.
  - A start in the DONE cycle is accepted.
  - ta_err holds until the next accepted start, which clears it.
- Clause 22 ops 00/11 are transmitted as written frames; no error is flagged.
- Latency: done asserts exactly 1 + 2*CLK_DIV*(PREAMBLE_LEN+32) cycles after the start cycle.

Test Plan:
- Clause 22 write, CLK_DIV=2, PREAMBLE_LEN=32, phy=5, reg=3, data=0xA5A5 -> 32 ones, then 01 01 00101 00011 10 1010010110100101; mdc period 4 clks; mdio_oe=1 throughout; done 257 cycles after start.
- Clause 22 read, phy=1, reg=2, peripheral model drives TA=0 and data 0x1234 -> mdio_oe falls at the first TA bit; rd_data=0x1234 and ta_err=0 at done.
- Clause 45 read (op=11) with no responder (mdio_in pulled to 1) -> ST=00, rd_data=0xFFFF, ta_err=1.
- start pulsed again mid-frame, then reset asserted at bit 40 -> second start ignored; after reset, all outputs at reset values and no done pulse.
- PREAMBLE_LEN=0, CLK_DIV=1, C45_EN=0 with c45=1 -> frame begins with ST=01 (Clause 22) and done arrives 65 cycles after start.
- Back-to-back: start held high in the DONE cycle -> new frame accepted; busy=1 on the next cycle; ta_err cleared.
